// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: steps a universal shift register through one transfer.
// The transfer is one parallel load, N shifts left or right, then a one-cycle done pulse.
// The register is held (mode 3) at all other times.
// Optional macro USR_SEQ_BACK_TO_BACK_EN: a start in DONE is accepted and goes straight to
// LOAD, so back-to-back transfers need no idle cycle between them.
// Mode is decoded combinationally from the registered state plus Pause_In/Abort_In. The USR
// samples it on the falling edge, so those two inputs must settle in the first half-cycle.

module usr_shift_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                 Clk_In,
  input  logic                 Reset_In,
  input  logic                 Start_In,
  input  logic                 Direction_In,
  input  logic [CNT_WIDTH-1:0] Shift_Count_In,
  input  logic                 Pause_In,
  input  logic                 Abort_In,
  output logic [1:0]           USR_Mode_Out,
  output logic                 Ready_Out,
  output logic                 Busy_Out,
  output logic                 Done_Out,
  output logic [CNT_WIDTH-1:0] Shift_Progress_Out
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [1:0] ModeLoad   = 2'd0;
  localparam logic [1:0] ModeRight  = 2'd1;
  localparam logic [1:0] ModeLeft   = 2'd2;
  localparam logic [1:0] ModeHold   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] FullCount = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CountOne  = CNT_WIDTH'(1);

  state_e               state_q;
  logic                 dir_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] remaining_q;
  logic [CNT_WIDTH-1:0] progress_q;

  // A programmed count of zero stands for a full-width transfer.
  logic [CNT_WIDTH-1:0] start_count;
  assign start_count = (Shift_Count_In == '0) ? FullCount : Shift_Count_In;

  // Sequencer state, latched transfer parameters and progress counter.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      count_q     <= '0;
      remaining_q <= '0;
      progress_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start_In) begin
            dir_q      <= Direction_In;
            count_q    <= start_count;
            progress_q <= '0;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          if (Abort_In) begin
            state_q <= StIdle;
          end else begin
            remaining_q <= count_q;
            state_q     <= StShift;
          end
        end
        StShift: begin
          if (Abort_In) begin
            state_q <= StIdle;
          end else if (!Pause_In) begin
            remaining_q <= remaining_q - CountOne;
            progress_q  <= progress_q + CountOne;
            if (remaining_q == CountOne) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
`ifdef USR_SEQ_BACK_TO_BACK_EN
          if (Start_In) begin
            dir_q      <= Direction_In;
            count_q    <= start_count;
            progress_q <= '0;
            state_q    <= StLoad;
          end else begin
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Mode decode; abort outranks pause, and pause has no effect during LOAD.
  always_comb begin
    USR_Mode_Out = ModeHold;
    unique case (state_q)
      StLoad:  USR_Mode_Out = Abort_In ? ModeHold : ModeLoad;
      StShift: begin
        if (Abort_In || Pause_In) begin
          USR_Mode_Out = ModeHold;
        end else begin
          USR_Mode_Out = dir_q ? ModeLeft : ModeRight;
        end
      end
      default: USR_Mode_Out = ModeHold;
    endcase
  end

  // Status outputs are decoded from the registered state.
  always_comb begin
    Busy_Out           = (state_q != StIdle);
    Done_Out           = (state_q == StDone);
    Shift_Progress_Out = progress_q;
`ifdef USR_SEQ_BACK_TO_BACK_EN
    Ready_Out          = (state_q == StIdle) || (state_q == StDone);
`else
    Ready_Out          = (state_q == StIdle);
`endif
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer with a behavioural 32-bit USR attached to the mode output.
// Per-cycle stimulus and expected outputs are queued together; each cycle pops one of each.

module tb_usr_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dir;
  logic [5:0] cnt;
  logic       pause;
  logic       abort;
  logic [1:0] mode;
  logic       ready;
  logic       busy;
  logic       done;
  logic [5:0] prog;

  usr_shift_sequencer #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (6)
  ) dut (
    .Clk_In            (clk),
    .Reset_In          (rst),
    .Start_In          (start),
    .Direction_In      (dir),
    .Shift_Count_In    (cnt),
    .Pause_In          (pause),
    .Abort_In          (abort),
    .USR_Mode_Out      (mode),
    .Ready_Out         (ready),
    .Busy_Out          (busy),
    .Done_Out          (done),
    .Shift_Progress_Out(prog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural USR: samples the mode on the falling edge; serial inputs tied low.
  logic [31:0] usr_par;
  logic [31:0] usr_q;
  always @(negedge clk or posedge rst) begin
    if (rst) usr_q <= '0;
    else begin
      case (mode)
        2'd0:    usr_q <= usr_par;
        2'd1:    usr_q <= {1'b0, usr_q[31:1]};
        2'd2:    usr_q <= {usr_q[30:0], 1'b0};
        default: usr_q <= usr_q;
      endcase
    end
  end

  typedef struct {
    logic       start;
    logic       dir;
    logic [5:0] cnt;
    logic       pause;
    logic       abort;
  } stim_t;

  typedef struct {
    logic [1:0] mode;
    logic       done;
    logic       busy;
    logic       ready;
    logic [5:0] prog;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_cmp;
  int    n_err;
  int    last_prog;
  int    mode2_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_cycle(input logic s, input logic d, input logic [5:0] c, input logic p,
                            input logic a, input logic [1:0] m, input logic dn, input logic b,
                            input logic r, input int pr);
    stim_t st;
    exp_t  ex;
    st = '{start: s, dir: d, cnt: c, pause: p, abort: a};
    ex = '{mode: m, done: dn, busy: b, ready: r, prog: 6'(pr)};
    stim_q.push_back(st);
    exp_q.push_back(ex);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cycle(0, 0, 0, 0, 0, 2'd3, 0, 0, 1, last_prog);
  endtask

  // Expected cycle-by-cycle trace of one transfer. Bit s of pause_mask pauses SHIFT-state
  // cycle s (bit 0 targets LOAD, where pause must be ignored); abort_at names a SHIFT-state
  // cycle (0 = none).
  task automatic push_transfer(input logic d, input logic [5:0] c, input logic [63:0] pause_mask,
                               input int abort_at, input logic hold, input logic skip_idle);
    int   n;
    int   k;
    int   s;
    logic rdy_done;
    n = (c == 0) ? 32 : int'(c);
`ifdef USR_SEQ_BACK_TO_BACK_EN
    rdy_done = 1'b1;
`else
    rdy_done = 1'b0;
`endif
    if (!skip_idle) push_cycle(1, d, c, 0, 0, 2'd3, 0, 0, 1, last_prog);
    push_cycle(hold, d, c, pause_mask[0], 0, 2'd0, 0, 1, 0, 0);
    k = 0;
    s = 1;
    while (k < n) begin
      if (s == abort_at) begin
        push_cycle(hold, d, c, pause_mask[s], 1, 2'd3, 0, 1, 0, k);
        last_prog = k;
        return;
      end
      if (pause_mask[s]) push_cycle(hold, d, c, 1, 0, 2'd3, 0, 1, 0, k);
      else begin
        push_cycle(hold, d, c, 0, 0, d ? 2'd2 : 2'd1, 0, 1, 0, k);
        k++;
      end
      s++;
    end
    push_cycle(hold, d, c, 0, 0, 2'd3, 1, 1, rdy_done, n);
    last_prog = n;
  endtask

  task automatic run_queue();
    stim_t st;
    exp_t  ex;
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      ex = exp_q.pop_front();
      @(posedge clk);
      #1;
      start = st.start;
      dir   = st.dir;
      cnt   = st.cnt;
      pause = st.pause;
      abort = st.abort;
      #1;
      if (mode == 2'd2) mode2_cnt++;
      check_eq("mode",  {30'd0, mode},  {30'd0, ex.mode});
      check_eq("done",  {31'd0, done},  {31'd0, ex.done});
      check_eq("busy",  {31'd0, busy},  {31'd0, ex.busy});
      check_eq("ready", {31'd0, ready}, {31'd0, ex.ready});
      check_eq("prog",  {26'd0, prog},  {26'd0, ex.prog});
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    last_prog = 0;
    mode2_cnt = 0;
    rst       = 1'b1;
    start     = 1'b0;
    dir       = 1'b0;
    cnt       = '0;
    pause     = 1'b0;
    abort     = 1'b0;
    usr_par   = 32'h0;

    #12;
    check_eq("rst_mode",  {30'd0, mode}, 32'd3);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_done",  {31'd0, done}, 32'd0);
    check_eq("rst_prog",  {26'd0, prog}, 32'd0);
    rst = 1'b0;

    // Full-width right transfer (count 0 means 32).
    push_idle(1);
    push_transfer(0, 6'd0, 64'd0, 0, 0, 0);
    push_idle(1);
    run_queue();

    // Left, count 5, pause on shift cycles 2-3 and during LOAD.
    mode2_cnt = 0;
    push_transfer(1, 6'd5, 64'b1101, 0, 0, 0);
    push_idle(1);
    run_queue();
    check_eq("mode2_cycles", mode2_cnt, 32'd5);

    // Count 10, abort on the 4th shift cycle; no done pulse, progress held at 3.
    push_transfer(0, 6'd10, 64'd0, 4, 0, 0);
    push_idle(2);
    run_queue();

    // Start held high through a count-3 transfer.
    push_transfer(0, 6'd3, 64'd0, 0, 1, 0);
`ifdef USR_SEQ_BACK_TO_BACK_EN
    push_transfer(0, 6'd3, 64'd0, 0, 0, 1);
`else
    push_transfer(0, 6'd3, 64'd0, 0, 0, 0);
`endif
    push_idle(1);
    run_queue();

    // Paired with the USR: 0x8000_0001 loaded, one right shift.
    usr_par = 32'h8000_0001;
    push_transfer(0, 6'd1, 64'd0, 0, 0, 0);
    push_idle(1);
    run_queue();
    check_eq("usr_value", usr_q, 32'h4000_0000);

    // Asynchronous reset in the middle of a count-20 shift.
    @(posedge clk);
    #1;
    start = 1'b1;
    dir   = 1'b0;
    cnt   = 6'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_mode", {30'd0, mode}, 32'd1);
    check_eq("mid_prog", {26'd0, prog}, 32'd4);
    rst = 1'b1;
    #1;
    check_eq("arst_mode",  {30'd0, mode}, 32'd3);
    check_eq("arst_busy",  {31'd0, busy}, 32'd0);
    check_eq("arst_ready", {31'd0, ready}, 32'd1);
    check_eq("arst_prog",  {26'd0, prog}, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    check_eq("post_rst_mode", {30'd0, mode}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
